// File: rtl/mem_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router_pkg
//  Description : Shared definitions for the data-side memory request router:
//                state encoding, default address map and target indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_router_pkg;

   // State encoding of the router transaction controller
   localparam logic [2:0] C_ST_IDLE  = 3'd0;
   localparam logic [2:0] C_ST_ISSUE = 3'd1;
   localparam logic [2:0] C_ST_WAIT  = 3'd2;
   localparam logic [2:0] C_ST_RESP  = 3'd3;
   localparam logic [2:0] C_ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = C_ST_IDLE,
      S_ISSUE = C_ST_ISSUE,
      S_WAIT  = C_ST_WAIT,
      S_RESP  = C_ST_RESP,
      S_ERR   = C_ST_ERR
   } state_t;

   // Default address map: target 0 below T1_BASE, target 1 up to ADDR_LIMIT
   localparam logic [31:0] C_T1_BASE_DEF    = 32'h0000_4000;
   localparam logic [31:0] C_ADDR_LIMIT_DEF = 32'h0000_8000;

   // Target indices as carried in the select bit
   localparam logic C_TGT0 = 1'b0;
   localparam logic C_TGT1 = 1'b1;

endpackage : mem_router_pkg
`default_nettype wire

// File: rtl/mem_router_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router_decode
//  Description : Combinational address decode for a memory router. Produces
//                the target select and a reject flag for misaligned or
//                out-of-range word accesses. Shared with the instruction side.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_router_decode
   import mem_router_pkg::*;
#(
   parameter logic [31:0] T1_BASE    = C_T1_BASE_DEF,
   parameter logic [31:0] ADDR_LIMIT = C_ADDR_LIMIT_DEF
) (
   input  logic [31:0] addr,
   output logic        sel,
   output logic        err
);

   logic w_misaligned;
   logic w_out_of_range;

   // Only full-word accesses are supported, so any low address bit set rejects
   assign w_misaligned   = (addr[1:0] != 2'b00);
   assign w_out_of_range = (addr >= ADDR_LIMIT);

   // Target 1 owns everything from T1_BASE upward; the limit check is separate
   assign sel = (addr >= T1_BASE) ? C_TGT1 : C_TGT0;
   assign err = w_misaligned | w_out_of_range;

endmodule : mem_router_decode
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
//  Module      : mem_router
//  Description : Single-master to dual-target memory request router for the
//                CPU data path. Accepts one load/store at a time, forwards it
//                to data RAM (target 0) or MMIO (target 1) by address, and
//                returns the owning target's completion as a one-cycle
//                response. Bad addresses are answered locally with an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_router
   import mem_router_pkg::*;
#(
   parameter logic [31:0] T1_BASE    = C_T1_BASE_DEF,
   parameter logic [31:0] ADDR_LIMIT = C_ADDR_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,

   // Master request / response
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,

   // Target 0 (data RAM)
   output logic        t0_valid,
   input  logic        t0_ready,
   output logic        t0_we,
   output logic [31:0] t0_addr,
   output logic [31:0] t0_wdata,
   input  logic        t0_rsp_valid,
   input  logic [31:0] t0_rdata,

   // Target 1 (MMIO)
   output logic        t1_valid,
   input  logic        t1_ready,
   output logic        t1_we,
   output logic [31:0] t1_addr,
   output logic [31:0] t1_wdata,
   input  logic        t1_rsp_valid,
   input  logic [31:0] t1_rdata,

   // Sticky protocol observation
   output logic        stray_rsp
);

   state_t      r_state;

   // Request register: the accepted transaction, presented to both targets
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_sel;

   // Registered outputs
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;
   logic        r_t0_valid;
   logic        r_t1_valid;
   logic        r_stray;

   // Decode results for the incoming address
   logic        w_dec_sel;
   logic        w_dec_err;

   // Handshake signals of the currently selected target
   logic        w_sel_ready;
   logic        w_sel_rsp_valid;
   logic [31:0] w_sel_rdata;

   // A completion that is not the one being waited for
   logic        w_t0_stray;
   logic        w_t1_stray;
   logic        w_waiting;

   mem_router_decode #(
      .T1_BASE    (T1_BASE),
      .ADDR_LIMIT (ADDR_LIMIT)
   ) u_decode (
      .addr (req_addr),
      .sel  (w_dec_sel),
      .err  (w_dec_err)
   );

   // Route the selected target's handshake back to the controller
   always_comb begin
      w_sel_ready     = t0_ready;
      w_sel_rsp_valid = t0_rsp_valid;
      w_sel_rdata     = t0_rdata;
      if (r_sel == C_TGT1) begin
         w_sel_ready     = t1_ready;
         w_sel_rsp_valid = t1_rsp_valid;
         w_sel_rdata     = t1_rdata;
      end
   end

   // Any completion outside WAIT, or from the other target, is stray
   always_comb begin
      w_waiting  = (r_state == S_WAIT);
      w_t0_stray = t0_rsp_valid & ~(w_waiting & (r_sel == C_TGT0));
      w_t1_stray = t1_rsp_valid & ~(w_waiting & (r_sel == C_TGT1));
   end

   // Transaction controller with all outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_sel       <= C_TGT0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_t0_valid  <= 1'b0;
         r_t1_valid  <= 1'b0;
         r_stray     <= 1'b0;
      end else begin
         // Sticky until reset; completions from a reset-abandoned
         // transaction land here as well
         if (w_t0_stray | w_t1_stray) begin
            r_stray <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_sel       <= w_dec_sel;
                  r_req_ready <= 1'b0;
                  if (w_dec_err) begin
                     // Rejected locally; neither target sees it
                     r_state     <= S_ERR;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_t0_valid <= (w_dec_sel == C_TGT0);
                     r_t1_valid <= (w_dec_sel == C_TGT1);
                  end
               end
            end

            S_ISSUE: begin
               // Hold valid and fields until the selected target takes it
               if (w_sel_ready) begin
                  r_t0_valid <= 1'b0;
                  r_t1_valid <= 1'b0;
                  r_state    <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (w_sel_rsp_valid) begin
                  // Stores return no data even if the target drives some
                  r_rsp_rdata <= r_we ? 32'h0000_0000 : w_sel_rdata;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end
            end

            S_RESP, S_ERR: begin
               // Response pulse lasts exactly one cycle, then reopen
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: begin
               r_t0_valid  <= 1'b0;
               r_t1_valid  <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

   assign t0_valid  = r_t0_valid;
   assign t0_we     = r_we;
   assign t0_addr   = r_addr;
   assign t0_wdata  = r_wdata;

   assign t1_valid  = r_t1_valid;
   assign t1_we     = r_we;
   assign t1_addr   = r_addr;
   assign t1_wdata  = r_wdata;

   assign stray_rsp = r_stray;

endmodule : mem_router
`default_nettype wire

// File: doc/mem_router.md
# mem_router

Single-master to dual-target memory request router for the MIPS CPU data path. Takes one load/store request stream from the MEM stage and dispatches it to target 0 (data RAM) or target 1 (MMIO) by address decode. It tracks the single outstanding transaction and returns the owning target's response on one response port. Misaligned and out-of-range addresses are rejected locally with an error response.

## Interface
Parameters:
- T1_BASE, 32'h0000_4000, first byte address routed to target 1; lower addresses go to target 0
- ADDR_LIMIT, 32'h0000_8000, first illegal byte address; addr >= ADDR_LIMIT is an error

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  master request valid
- req_ready  out  1  router can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response pulse to master
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: request rejected
- tN_valid  out  1  request to target N (N = 0, 1)
- tN_ready  in  1  target N accepts request
- tN_we / tN_addr / tN_wdata  out  1/32/32  registered copy of accepted request
- tN_rsp_valid  in  1  target N completion (loads and stores)
- tN_rdata  in  32  target N load data
- stray_rsp  out  1  sticky: response seen from a target not being waited on

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE: req_ready = 1. On req_valid: latch we/addr/wdata into request register; sel = (addr >= T1_BASE). If addr[1:0] != 0 or addr >= ADDR_LIMIT -> ERR, else -> ISSUE.
- ISSUE: t[sel]_valid = 1 with registered fields; other target's valid = 0. Stay until t[sel]_ready, then -> WAIT. Fields stable while valid is high.
- WAIT: wait for t[sel]_rsp_valid; capture t[sel]_rdata (or 0 if store) into rsp_rdata -> RESP.
- RESP: rsp_valid = 1, rsp_err = 0 for exactly one cycle -> IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 for one cycle -> IDLE. No target is touched.
- req_ready = 0 in every state except IDLE; one transaction outstanding at most.
- tN_rsp_valid from the non-selected target, or from any target outside WAIT, is ignored and sets stray_rsp; cleared only by rst.
- Simultaneous t0_rsp_valid and t1_rsp_valid in WAIT: only the selected one is consumed; the other sets stray_rsp.
- Reset: state = IDLE; req_ready = 1 after reset; rsp_valid, rsp_err, t0_valid, t1_valid, stray_rsp = 0; rsp_rdata and request register = 0. Reset mid-transaction abandons it; late target responses after reset set stray_rsp.

## Timing
- Accept at cycle 0 -> t[sel]_valid at cycle 1.
- Target ready at cycle 1 -> WAIT from cycle 2; earliest target response sampled at cycle 2 -> rsp_valid at cycle 3. Minimum round trip 3 cycles.
- Error path: accept at cycle 0 -> rsp_valid/rsp_err at cycle 1.
- All outputs registered or decoded from state register only; no combinational path from any input to any output except none (req_ready from state).

## Structure
- Shared package: state encoding constants, default T1_BASE/ADDR_LIMIT, target index constants.
- Sub-module: mem_router_decode (combinational: addr -> sel, err), reused later by the instruction-side router.

## Test plan
- Load to 0x0000_0010, t0_ready immediate, t0_rsp_valid at cycle 2 with 0xDEADBEEF -> t0_valid cycle 1 only, rsp_valid cycle 3, rsp_rdata 0xDEADBEEF, rsp_err 0.
- Store to 0x0000_4004 data 0x12345678, t1_ready held low 4 cycles -> t1_valid high 5 cycles with stable addr/wdata, t0_valid never high, rsp_rdata 0.
- Load from 0x0000_0006 (misaligned) and 0x0000_8000 (out of range) -> rsp_valid/rsp_err at cycle 1, no tN_valid.
- During WAIT on target 0, pulse t1_rsp_valid -> ignored, stray_rsp = 1 until rst; transaction completes normally.
- Back-to-back req_valid held high -> second request accepted only in the cycle after RESP (req_ready low throughout).
- Assert rst in WAIT -> next cycle IDLE, all outputs at reset values, req_ready = 1.
